// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache memory-port arbiter: FSM state encoding and
// line-offset helpers used to align latched addresses.
package arbiter_types;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ICACHE,
    ARB_DCACHE,
    ARB_DONE
  } arb_state_t;

  localparam int DEFAULT_LINE_WIDTH = 256;
  localparam int LINE_OFFSET_BITS   = $clog2(DEFAULT_LINE_WIDTH / 8);

  function automatic int line_offset_bits(input int line_width);
    return $clog2(line_width / 8);
  endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates one physical memory port between the I-cache and the D-cache.
// D has priority; a starvation counter forces an I grant after STARVE_LIMIT passes.
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_pmem_read,
  input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
  output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
  output logic                  icache_pmem_resp,
  input  logic                  dcache_pmem_read,
  input  logic                  dcache_pmem_write,
  input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
  input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
  output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
  output logic                  dcache_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam int OFF = line_offset_bits(LINE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((64'd1 << OFF) - 64'd1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // Handshake: a requester holds its read/write level until the matching resp
  // pulse; the arbiter completes every granted transaction even if the level drops.
  arb_state_t state_q, state_d;
  logic [3:0]            starve_cnt, starve_d;
  logic [ADDR_WIDTH-1:0] addr_lat, addr_d;
  logic [LINE_WIDTH-1:0] wdata_lat, wdata_d;
  logic                  wr_lat, wr_d;
  logic                  i_req, d_req;

  assign i_req = icache_pmem_read;
  assign d_req = dcache_pmem_read | dcache_pmem_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      starve_cnt <= '0;
      addr_lat   <= '0;
      wdata_lat  <= '0;
      wr_lat     <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_cnt <= starve_d;
      addr_lat   <= addr_d;
      wdata_lat  <= wdata_d;
      wr_lat     <= wr_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    starve_d          = starve_cnt;
    addr_d            = addr_lat;
    wdata_d           = wdata_lat;
    wr_d              = wr_lat;
    pmem_read         = 1'b0;
    pmem_write        = 1'b0;
    icache_pmem_resp  = 1'b0;
    dcache_pmem_resp  = 1'b0;
    icache_pmem_rdata = '0;
    dcache_pmem_rdata = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (d_req && (!i_req || starve_cnt < STARVE_MAX)) begin
          state_d = ARB_DCACHE;
          addr_d  = dcache_pmem_address & ALIGN_MASK;
          wdata_d = dcache_pmem_wdata;
          // An illegal read+write request is resolved as a write.
          wr_d    = dcache_pmem_write;
          if (i_req) starve_d = starve_cnt + 4'd1;
        end else if (i_req) begin
          state_d  = ARB_ICACHE;
          addr_d   = icache_pmem_address & ALIGN_MASK;
          wr_d     = 1'b0;
          starve_d = '0;
        end
      end
      ARB_ICACHE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          icache_pmem_resp  = 1'b1;
          icache_pmem_rdata = pmem_rdata;
          state_d           = ARB_DONE;
        end
      end
      ARB_DCACHE: begin
        pmem_read  = !wr_lat;
        pmem_write = wr_lat;
        if (pmem_resp) begin
          dcache_pmem_resp  = 1'b1;
          dcache_pmem_rdata = pmem_rdata;
          state_d           = ARB_DONE;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
    endcase
  end

  assign pmem_address = addr_lat;
  assign pmem_wdata   = wdata_lat;

  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(dcache_pmem_read && dcache_pmem_write))
      else $warning("cache_arbiter: dcache read and write both high, treated as write");
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a transaction-level model.
module tb_cache_arbiter;
  import arbiter_types::*;

  localparam int LW = 256;
  localparam int AW = 32;
  localparam int SL = 4;
  localparam logic [AW-1:0] LINE_BYTES = AW'(LW / 8);

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_pmem_read;
  logic [AW-1:0] icache_pmem_address;
  logic [LW-1:0] icache_pmem_rdata;
  logic          icache_pmem_resp;
  logic          dcache_pmem_read;
  logic          dcache_pmem_write;
  logic [AW-1:0] dcache_pmem_address;
  logic [LW-1:0] dcache_pmem_wdata;
  logic [LW-1:0] dcache_pmem_rdata;
  logic          dcache_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .icache_pmem_read(icache_pmem_read), .icache_pmem_address(icache_pmem_address),
    .icache_pmem_rdata(icache_pmem_rdata), .icache_pmem_resp(icache_pmem_resp),
    .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
    .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
    .dcache_pmem_rdata(dcache_pmem_rdata), .dcache_pmem_resp(dcache_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests_run = 0;
  int failures  = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // ---------------- behavioural model + scoreboard ----------------
  // phase: 0 waiting for a request, 1 transaction in flight, 2 one-cycle gap.
  int            m_phase;
  bit            m_owner_i;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  int            m_starve;
  logic [1:0]    exp_q[$];   // grant log: 1 = I, 2 = D

  always @(negedge clk) begin
    bit            busy, e_read, e_write, e_ri, e_rd, ireq, dreq;
    logic [LW-1:0] e_rdi, e_rdd;
    if (rst) begin
      m_phase = 0; m_owner_i = 0; m_wr = 0; m_addr = '0; m_wdata = '0; m_starve = 0;
    end
    busy    = (m_phase == 1);
    e_read  = busy && (m_owner_i || !m_wr);
    e_write = busy && !m_owner_i && m_wr;
    e_ri    = busy && m_owner_i && pmem_resp;
    e_rd    = busy && !m_owner_i && pmem_resp;
    e_rdi   = e_ri ? pmem_rdata : '0;
    e_rdd   = e_rd ? pmem_rdata : '0;
    check("pmem_read",    LW'(pmem_read),         LW'(e_read));
    check("pmem_write",   LW'(pmem_write),        LW'(e_write));
    check("pmem_address", LW'(pmem_address),      LW'(m_addr));
    check("pmem_wdata",   pmem_wdata,             m_wdata);
    check("icache_resp",  LW'(icache_pmem_resp),  LW'(e_ri));
    check("dcache_resp",  LW'(dcache_pmem_resp),  LW'(e_rd));
    check("icache_rdata", icache_pmem_rdata,      e_rdi);
    check("dcache_rdata", dcache_pmem_rdata,      e_rdd);
    check("starve_cnt",   LW'(dut.starve_cnt),    LW'(m_starve));
    if (!rst) begin
      ireq = icache_pmem_read;
      dreq = dcache_pmem_read || dcache_pmem_write;
      if (m_phase == 0) begin
        if (dreq && (!ireq || m_starve < SL)) begin
          if (ireq) m_starve++;
          m_phase = 1; m_owner_i = 0; m_wr = dcache_pmem_write;
          m_addr  = (dcache_pmem_address / LINE_BYTES) * LINE_BYTES;
          m_wdata = dcache_pmem_wdata;
          exp_q.push_back(2'd2);
        end else if (ireq) begin
          m_starve = 0;
          m_phase = 1; m_owner_i = 1; m_wr = 0;
          m_addr  = (icache_pmem_address / LINE_BYTES) * LINE_BYTES;
          exp_q.push_back(2'd1);
        end
      end else if (m_phase == 1) begin
        if (pmem_resp) m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    icache_pmem_read = 0; icache_pmem_address = '0;
    dcache_pmem_read = 0; dcache_pmem_write = 0;
    dcache_pmem_address = '0; dcache_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
  endtask

  task automatic reset_pulse();
    rst = 1;
    tick();
    rst = 0;
  endtask

  // ---------------- stimulus ----------------
  logic [LW-1:0] line_a5, line_1234, tmp;
  logic [1:0]    seq[6];
  logic [1:0]    who;
  bit            i_got, d_got, mem_busy;
  int            mem_cnt;

  initial begin
    line_a5   = {32{8'hA5}};
    line_1234 = {8{32'h1234_5678}};
    seq = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2};
    rst = 1;
    clear_inputs();
    tick(); tick();
    #1;
    check("reset_state",  LW'(dut.state_q),   LW'(ARB_IDLE));
    check("reset_strobe", LW'({pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp}), '0);
    check("reset_addr",   LW'(pmem_address),  '0);
    rst = 0;
    tick();

    // Lone I read with an unaligned address.
    icache_pmem_read = 1; icache_pmem_address = 32'h0000_0064;
    tick(); #1;
    check("i_read_strobe", LW'(pmem_read), LW'(1'b1));
    check("i_read_addr",   LW'(pmem_address), LW'(32'h0000_0060));
    pmem_resp = 1; pmem_rdata = line_a5; #1;
    check("i_resp",       LW'(icache_pmem_resp), LW'(1'b1));
    check("i_rdata",      icache_pmem_rdata, line_a5);
    check("i_resp_d_low", LW'(dcache_pmem_resp), '0);
    tick();
    pmem_resp = 0; icache_pmem_read = 0; #1;
    check("i_resp_pulse", LW'(icache_pmem_resp), '0);
    tick();

    // D write; wdata changes mid-service must not leak through.
    dcache_pmem_write = 1; dcache_pmem_address = 32'h8000_0020; dcache_pmem_wdata = line_1234;
    tick(); #1;
    check("d_wr_strobe", LW'({pmem_read, pmem_write}), LW'(2'b01));
    check("d_wr_wdata",  pmem_wdata, line_1234);
    check("d_wr_addr",   LW'(pmem_address), LW'(32'h8000_0020));
    dcache_pmem_wdata = ~line_1234;
    tick(); #1;
    check("d_wr_hold", pmem_wdata, line_1234);
    pmem_resp = 1; #1;
    check("d_wr_resp", LW'(dcache_pmem_resp), LW'(1'b1));
    tick();
    pmem_resp = 0; dcache_pmem_write = 0; #1;
    check("d_wr_single_pulse", LW'(dcache_pmem_resp), '0);
    tick();

    // Starvation: both request, D keeps re-requesting.
    reset_pulse();
    exp_q.delete();
    icache_pmem_read = 1; icache_pmem_address = 32'h0000_1000;
    dcache_pmem_read = 1; dcache_pmem_address = 32'h0000_2000;
    for (int k = 0; k < 6; k++) begin
      tick();
      pmem_resp = 1; pmem_rdata = rand_line(); #1;
      who = icache_pmem_resp ? 2'd1 : (dcache_pmem_resp ? 2'd2 : 2'd0);
      check($sformatf("starve_grant_%0d", k), LW'(who), LW'(seq[k]));
      if (who == 2'd1) check("starve_cleared", LW'(dut.starve_cnt), '0);
      tick();
      pmem_resp = 0;
      if (who == 2'd1) icache_pmem_read = 0;
      tick();
    end
    check("model_grant_count", LW'(exp_q.size()), LW'(6));
    for (int k = 0; k < 6 && k < exp_q.size(); k++)
      check($sformatf("model_grant_%0d", k), LW'(exp_q[k]), LW'(seq[k]));
    dcache_pmem_read = 0;
    tick(); tick();

    // Back-to-back D reads: DONE gap between transactions.
    dcache_pmem_read = 1; dcache_pmem_address = 32'h0000_0300;
    tick();
    pmem_resp = 1; #1;
    check("b2b_n_read", LW'(pmem_read), LW'(1'b1));
    tick();
    pmem_resp = 0; #1;
    check("b2b_n1_read", LW'(pmem_read), '0);
    tick(); #1;
    check("b2b_n2_read", LW'(pmem_read), '0);
    tick(); #1;
    check("b2b_n3_read", LW'(pmem_read), LW'(1'b1));
    pmem_resp = 1; #1;
    tick();
    pmem_resp = 0; dcache_pmem_read = 0;
    tick(); tick();

    // Spurious pmem_resp in IDLE.
    pmem_resp = 1; pmem_rdata = line_a5; #1;
    check("spurious_resp", LW'({icache_pmem_resp, dcache_pmem_resp}), '0);
    check("spurious_rdata", dcache_pmem_rdata | icache_pmem_rdata, '0);
    tick();
    pmem_resp = 0;
    tick();

    // Reset mid-ARB_DCACHE, then a late pmem_resp.
    dcache_pmem_read = 1; dcache_pmem_address = 32'h0000_0440;
    tick(); #1;
    check("rst_pre_strobe", LW'(pmem_read), LW'(1'b1));
    rst = 1; pmem_resp = 1; #1;
    check("rst_strobes", LW'({pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp}), '0);
    check("rst_addr", LW'(pmem_address), '0);
    tick();
    rst = 0; dcache_pmem_read = 0; pmem_resp = 1; #1;
    check("rst_late_resp", LW'({icache_pmem_resp, dcache_pmem_resp}), '0);
    tick();
    pmem_resp = 0;
    tick();

    // Illegal read+write: treated as a write.
    dcache_pmem_read = 1; dcache_pmem_write = 1; dcache_pmem_wdata = line_a5;
    dcache_pmem_address = 32'h0000_0500;
    tick(); #1;
    check("illegal_is_write", LW'({pmem_read, pmem_write}), LW'(2'b01));
    dcache_pmem_read = 0; dcache_pmem_write = 0;
    pmem_resp = 1;
    tick();
    pmem_resp = 0;
    tick(); tick();

    // Randomized traffic with a random-latency memory.
    i_got = 0; d_got = 0; mem_busy = 0; mem_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      pmem_resp = 0;
      if (!mem_busy && (pmem_read || pmem_write)) begin
        mem_busy = 1; mem_cnt = $urandom_range(0, 3);
      end
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          pmem_resp = 1; pmem_rdata = rand_line(); mem_busy = 0;
        end else mem_cnt--;
      end else if ($urandom_range(0, 19) == 0) begin
        pmem_resp = 1; pmem_rdata = rand_line();
      end
      #1;
      if (c == 1500) begin
        rst = 1; clear_inputs(); i_got = 0; d_got = 0; mem_busy = 0;
      end else begin
        rst = 0;
        if (i_got) begin icache_pmem_read = 0; i_got = 0; end
        else if (!icache_pmem_read && $urandom_range(0, 3) == 0) begin
          icache_pmem_read = 1; icache_pmem_address = $urandom();
        end else if (icache_pmem_read && $urandom_range(0, 7) == 0)
          icache_pmem_address = $urandom();
        if (d_got) begin dcache_pmem_read = 0; dcache_pmem_write = 0; d_got = 0; end
        else if (!dcache_pmem_read && !dcache_pmem_write && $urandom_range(0, 2) == 0) begin
          tmp = rand_line();
          if ($urandom_range(0, 1) == 1) dcache_pmem_write = 1; else dcache_pmem_read = 1;
          dcache_pmem_address = $urandom(); dcache_pmem_wdata = tmp;
        end else if ($urandom_range(0, 7) == 0) begin
          dcache_pmem_wdata = rand_line(); dcache_pmem_address = $urandom();
        end
      end
      #1;
      if (icache_pmem_resp) i_got = 1;
      if (dcache_pmem_resp) d_got = 1;
    end
    rst = 0;
    clear_inputs();
    tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical memory port between the instruction cache and the data cache of the pipelined RV32I core.
- Serves one line-sized read or write transaction at a time, always to completion.
- Latches the winning request and forwards the response only to the requester that was granted.
- The data cache has priority; a starvation counter bounds how long the instruction cache can be locked out.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- ADDR_WIDTH, 32, byte address width.
- STARVE_LIMIT, 4, number of consecutive D grants that may pass over a waiting I request; range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- icache_pmem_read  in  1  I-side line read request, held until its resp
- icache_pmem_address  in  ADDR_WIDTH  I-side line address
- icache_pmem_rdata  out  LINE_WIDTH  I-side read line
- icache_pmem_resp  out  1  I-side done pulse
- dcache_pmem_read  in  1  D-side line read request
- dcache_pmem_write  in  1  D-side line write-back request
- dcache_pmem_address  in  ADDR_WIDTH  D-side line address
- dcache_pmem_wdata  in  LINE_WIDTH  D-side write line
- dcache_pmem_rdata  out  LINE_WIDTH  D-side read line
- dcache_pmem_resp  out  1  D-side done pulse
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  ADDR_WIDTH  memory address, line-aligned
- pmem_wdata  out  LINE_WIDTH  memory write line
- pmem_rdata  in  LINE_WIDTH  memory read line
- pmem_resp  in  1  memory done pulse

Behaviour:
- Reset values:
  - State goes to ARB_IDLE; starve_cnt = 0.
  - All latches clear; every output is 0.
- State machine: ARB_IDLE, ARB_ICACHE, ARB_DCACHE, ARB_DONE.
  - The state register updates on the clk rising edge.
  - pmem_* strobes are decoded from state and latched fields.
- Requests:
  - i_req = icache_pmem_read.
  - d_req = dcache_pmem_read | dcache_pmem_write.
- Grant decision in ARB_IDLE:
  - Only d_req: go to ARB_DCACHE.
  - Only i_req: go to ARB_ICACHE.
  - Both, starve_cnt < STARVE_LIMIT: go to ARB_DCACHE and increment starve_cnt.
  - Both, starve_cnt == STARVE_LIMIT: go to ARB_ICACHE.
  - Any I grant clears starve_cnt.
  - A D grant while i_req is low leaves starve_cnt unchanged.
- Latching at grant: on the IDLE->serve edge, latch address, wdata and the write bit (D only).
  - The low log2(LINE_WIDTH/8) address bits are forced to 0.
  - Later changes on requester inputs have no effect until the next grant.
- Serve states:
  - ARB_ICACHE: pmem_read = 1.
  - ARB_DCACHE: pmem_read = !wr_lat and pmem_write = wr_lat.
  - pmem_address and pmem_wdata come from the latches.
- Completion, on pmem_resp = 1 in a serve state, in the same cycle:
  - The granted client's resp = 1 and its rdata = pmem_rdata, combinationally.
  - The other client's resp = 0.
  - The next state is ARB_DONE.
- ARB_DONE:
  - Lasts exactly one cycle with all strobes and resps at 0.
  - This lets the served cache drop its request before re-arbitration; the next state is ARB_IDLE.
- Latency: request seen in IDLE at cycle t; strobe at t+1; resp forwarded in the cycle pmem_resp arrives; next grant no earlier than resp+2.
- rdata when idle: rdata outputs are 0 whenever the matching resp is 0.
- pmem_resp while in ARB_IDLE or ARB_DONE is ignored and forwards nothing.
- dcache_pmem_read and dcache_pmem_write both high is illegal. A simulation assertion fires; RTL treats the request as a write.
- A requester dropping its request mid-service does not abort the transaction. The memory transaction completes and the resp pulse is still driven.
- rst asserted mid-transaction:
  - Immediate return to ARB_IDLE; all outputs go to 0 asynchronously.
  - Any in-flight pmem_resp after reset release is ignored, per the IDLE rule.

Decomposition:
- Shared package arbiter_types holds:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_ICACHE, ARB_DCACHE, ARB_DONE}.
  - Localparam LINE_OFFSET_BITS = $clog2(LINE_WIDTH/8).
- Single module, no sub-module: the starvation counter and latches are small enough inline.

Test Plan:
- Lone I read, addr 0x0000_0064:
  - pmem_read = 1 and pmem_address = 0x0000_0060 one cycle later.
  - pmem_resp with rdata = 256'hA5..A5 gives icache_pmem_resp = 1 and matching rdata for 1 cycle; dcache_pmem_resp stays 0.
- D write, addr 0x8000_0020, wdata = 256'h1234..:
  - pmem_write = 1 with the latched wdata.
  - Changing dcache_pmem_wdata mid-service leaves pmem_wdata unchanged; dcache_pmem_resp pulses once.
- I and D requesting together from reset, D re-requesting after each completion, STARVE_LIMIT = 4:
  - Grant order is D,D,D,D,I, then D resumes.
  - starve_cnt reads 0 after the I grant.
- Back-to-back D reads: resp at cycle n, then pmem_read low at n+1 (ARB_DONE), then pmem_read high again no earlier than n+2.
- Spurious pmem_resp in IDLE: no client resp is asserted.
- rst pulsed mid-ARB_DCACHE:
  - All outputs 0 within the reset cycle.
  - A late pmem_resp after release produces no client resp.
- dcache read and write both high: the assertion fires and the arbiter issues pmem_write.
